// File: rtl/game_pkg.sv
// Shared types for the game-time logger. GAME_LOG_DELTA_EN adds a per-entry
// capture interval next to each timestamp.
package game_pkg;

  localparam int GAME_TS_W      = 10;
  localparam int GAME_LOG_DEPTH = 8;

  typedef logic [GAME_TS_W-1:0] game_ts_t;

  typedef struct packed {
    game_ts_t ts;
`ifdef GAME_LOG_DELTA_EN
    game_ts_t delta;
`endif
  } game_log_entry_t;

  // Stored entry width for a given timestamp width.
  function automatic int game_entry_w(input int ts_w);
`ifdef GAME_LOG_DELTA_EN
    return 2 * ts_w;
`else
    return ts_w;
`endif
  endfunction

endpackage

// File: rtl/game_log_fifo.sv
// Synchronous FIFO with extra-MSB pointers, registered storage and a
// combinational head view. clear wins over same-cycle push/pop.
module game_log_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wr_data,
  output logic [W-1:0]           rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          do_push, do_pop;
  logic [W-1:0]  mem [DEPTH];

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // A pop on a full FIFO frees the slot the push lands in.
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
      logic [W-1:0] entry_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          entry_reg <= '0;
        else if (do_push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
          entry_reg <= wr_data;
      end

      assign mem[gi] = entry_reg;
    end
  endgenerate

  assign rd_data = mem[rd_ptr_reg[AW-1:0]];
  assign level   = wr_ptr_reg - rd_ptr_reg;

endmodule

// File: rtl/game_time_logger.sv
// Captures the game-time counter on each write strobe into a small FIFO and
// flags tick-stream inconsistencies. GAME_LOG_DELTA_EN adds rd_delta.
module game_time_logger
  import game_pkg::*;
#(
  parameter int DEPTH = GAME_LOG_DEPTH,
  parameter int TS_W  = GAME_TS_W
) (
  input  logic                   CLOCK50M,
  input  logic                   KEY0,
  input  logic [TS_W-1:0]        counter_in,
  input  logic                   counter_update,
  input  logic                   write_100m,
  input  logic                   clear,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [TS_W-1:0]        rd_ts,
`ifdef GAME_LOG_DELTA_EN
  output logic [TS_W-1:0]        rd_delta,
`endif
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   seq_err
);

  localparam int ENTRY_W = game_entry_w(TS_W);

  logic               fifo_full, fifo_empty;
  logic               pop, accept;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;
  logic [TS_W-1:0]    prev_ts_reg, prev_plus1;
  logic               step_bad;
  logic               overflow_reg, overflow_next;
  logic               seq_err_reg, seq_err_next;

  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;
  assign accept   = write_100m && (!fifo_full || pop) && !clear;

`ifdef GAME_LOG_DELTA_EN
  logic [TS_W-1:0] last_cap_reg, last_cap_next;

  always_comb begin
    last_cap_next = last_cap_reg;
    if (clear)
      last_cap_next = '0;
    else if (accept)
      last_cap_next = counter_in;
  end

  always_ff @(posedge CLOCK50M or posedge KEY0) begin
    if (KEY0)
      last_cap_reg <= '0;
    else
      last_cap_reg <= last_cap_next;
  end

  // Subtraction wraps naturally at TS_W bits.
  assign wr_entry = {counter_in, counter_in - last_cap_reg};
  assign rd_ts    = rd_entry[ENTRY_W-1:TS_W];
  assign rd_delta = rd_entry[TS_W-1:0];
`else
  assign wr_entry = counter_in;
  assign rd_ts    = rd_entry;
`endif

  game_log_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk     (CLOCK50M),
    .rst     (KEY0),
    .clear   (clear),
    .push    (accept),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign prev_plus1 = prev_ts_reg + TS_W'(1);

  // Free-running jumps to zero are the game's own reset path, not an error.
  always_comb begin
    step_bad = 1'b0;
    if (counter_update)
      step_bad = (counter_in != prev_plus1);
    else
      step_bad = (counter_in != prev_ts_reg) && (counter_in != '0);
  end

  always_comb begin
    overflow_next = overflow_reg;
    seq_err_next  = seq_err_reg;
    if (clear) begin
      overflow_next = 1'b0;
      seq_err_next  = 1'b0;
    end else begin
      if (write_100m && fifo_full && !pop) overflow_next = 1'b1;
      if (step_bad)                        seq_err_next  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK50M or posedge KEY0) begin
    if (KEY0) begin
      prev_ts_reg  <= '0;
      overflow_reg <= 1'b0;
      seq_err_reg  <= 1'b0;
    end else begin
      prev_ts_reg  <= counter_in;
      overflow_reg <= overflow_next;
      seq_err_reg  <= seq_err_next;
    end
  end

  assign overflow = overflow_reg;
  assign seq_err  = seq_err_reg;

endmodule

// File: tb/tb_game_time_logger.sv
// Bench for game_time_logger: directed table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_game_time_logger;
  import game_pkg::*;

  localparam int DEPTH = 8;

  logic     CLOCK50M = 1'b0;
  logic     KEY0;
  game_ts_t counter_in;
  logic     counter_update, write_100m, clear, rd_ready;
  logic     rd_valid;
  game_ts_t rd_ts;
`ifdef GAME_LOG_DELTA_EN
  game_ts_t rd_delta;
`endif
  logic [$clog2(DEPTH):0] level;
  logic     overflow, seq_err;

  game_time_logger #(.DEPTH(DEPTH), .TS_W(GAME_TS_W)) dut (
    .CLOCK50M       (CLOCK50M),
    .KEY0           (KEY0),
    .counter_in     (counter_in),
    .counter_update (counter_update),
    .write_100m     (write_100m),
    .clear          (clear),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_ts          (rd_ts),
`ifdef GAME_LOG_DELTA_EN
    .rd_delta       (rd_delta),
`endif
    .level          (level),
    .overflow       (overflow),
    .seq_err        (seq_err)
  );

  always #5 CLOCK50M = ~CLOCK50M;

  typedef struct {
    game_ts_t ts;
    game_ts_t delta;
  } ent_t;

  ent_t     q[$];
  logic     m_ovf, m_err;
  game_ts_t m_prev, m_last;
  int       pass_cnt = 0;
  int       total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    m_prev = '0;
    m_last = '0;
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_edge();
    bit popped, room;
    if (clear) begin
      q.delete();
      m_ovf  = 1'b0;
      m_err  = 1'b0;
      m_last = '0;
    end else begin
      popped = (q.size() > 0) && rd_ready;
      room   = q.size() < DEPTH;
      if (popped) begin
        $display("pop  ts=%0d delta=%0d", q[0].ts, q[0].delta);
        void'(q.pop_front());
      end
      if (write_100m) begin
        if (room || popped) begin
          q.push_back('{counter_in, game_ts_t'(counter_in - m_last)});
          m_last = counter_in;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (counter_update) begin
        if (counter_in != game_ts_t'(m_prev + 1)) m_err = 1'b1;
      end else if (counter_in != m_prev && counter_in != 0) begin
        m_err = 1'b1;
      end
    end
    m_prev = counter_in;
  endtask

  task automatic cycle(input bit w, input bit u, input bit clr, input bit rdy, input game_ts_t c);
    write_100m     = w;
    counter_update = u;
    clear          = clr;
    rd_ready       = rdy;
    counter_in     = c;
    @(posedge CLOCK50M);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, rd_valid, q.size() != 0);
    chk({tag, ".level"}, level, q.size());
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".err"}, seq_err, m_err);
    if (q.size() != 0) begin
      chk({tag, ".ts"}, rd_ts, q[0].ts);
`ifdef GAME_LOG_DELTA_EN
      chk({tag, ".delta"}, rd_delta, q[0].delta);
`endif
    end
  endtask

  // Called just after an edge; reset pulse stays clear of the next edge.
  task automatic do_reset();
    write_100m = 0; counter_update = 0; clear = 0; rd_ready = 0; counter_in = '0;
    #2 KEY0 = 1'b1;
    model_reset();
    #2 KEY0 = 1'b0;
  endtask

  typedef struct {
    bit       wr, upd, rdy;
    game_ts_t cnt;
    bit       e_valid;
    int       e_level;
    game_ts_t e_ts;
    game_ts_t e_delta;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    KEY0 = 1'b1;
    write_100m = 0; counter_update = 0; clear = 0; rd_ready = 0; counter_in = '0;
    model_reset();
    #3;
    chk("reset.valid", rd_valid, 0);
    chk("reset.ts", rd_ts, 0);
`ifdef GAME_LOG_DELTA_EN
    chk("reset.delta", rd_delta, 0);
`endif
    chk("reset.level", level, 0);
    chk("reset.ovf", overflow, 0);
    chk("reset.err", seq_err, 0);
    #4 KEY0 = 1'b0;
    @(posedge CLOCK50M); #1;

    // Directed table: legal ticks 1..4, captures at 5,6,7, then drain.
    tbl[0] = '{0, 1, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 2, 0, 0, 0, 0};
    tbl[2] = '{0, 1, 0, 3, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 4, 0, 0, 0, 0};
    tbl[4] = '{1, 1, 0, 5, 1, 1, 5, 5};
    tbl[5] = '{1, 1, 0, 6, 1, 2, 5, 5};
    tbl[6] = '{1, 1, 0, 7, 1, 3, 5, 5};
    tbl[7] = '{0, 0, 1, 7, 1, 2, 6, 1};
    tbl[8] = '{0, 0, 1, 7, 1, 1, 7, 1};
    tbl[9] = '{0, 0, 1, 7, 0, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].wr, tbl[i].upd, 0, tbl[i].rdy, tbl[i].cnt);
      $display("vec %0d: wr=%0d upd=%0d rdy=%0d cnt=%0d -> valid=%0d level=%0d ts=%0d",
               i, tbl[i].wr, tbl[i].upd, tbl[i].rdy, tbl[i].cnt, rd_valid, level, rd_ts);
      chk($sformatf("vec%0d.valid", i), rd_valid, tbl[i].e_valid);
      chk($sformatf("vec%0d.level", i), level, tbl[i].e_level);
      chk($sformatf("vec%0d.err", i), seq_err, 0);
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d.ts", i), rd_ts, tbl[i].e_ts);
`ifdef GAME_LOG_DELTA_EN
        chk($sformatf("vec%0d.delta", i), rd_delta, tbl[i].e_delta);
`endif
      end
    end

    // Overflow: fill, one extra strobe is dropped and never appears.
    do_reset();
    for (int i = 1; i <= 8; i++) cycle(1, 1, 0, 0, game_ts_t'(i));
    chk("fill.level", level, 8);
    chk("fill.ovf", overflow, 0);
    cycle(1, 1, 0, 0, 9);
    $display("overflow strobe: level=%0d overflow=%0d", level, overflow);
    chk("drop.level", level, 8);
    chk("drop.ovf", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drop.head%0d", i), rd_ts, i);
      cycle(0, 0, 0, 1, 9);
    end
    chk("drop.empty", rd_valid, 0);
    chk("drop.ovf_hold", overflow, 1);

    // Full FIFO with simultaneous write and pop.
    cycle(0, 0, 1, 0, 9);
    chk("clear.ovf", overflow, 0);
    chk("clear.level", level, 0);
    for (int i = 10; i <= 17; i++) cycle(1, 1, 0, 0, game_ts_t'(i));
    cycle(1, 1, 0, 1, 18);
    $display("full write+pop: level=%0d overflow=%0d head=%0d", level, overflow, rd_ts);
    chk("wrpop.level", level, 8);
    chk("wrpop.ovf", overflow, 0);
    for (int i = 11; i <= 18; i++) begin
      chk($sformatf("wrpop.head%0d", i), rd_ts, i);
      cycle(0, 0, 0, 1, 18);
    end
    chk("wrpop.empty", rd_valid, 0);

    // Tick check: skipped count, then a game reset to zero.
    cycle(0, 0, 1, 0, 41);
    chk("seq.clear", seq_err, 0);
    cycle(0, 1, 0, 0, 43);
    $display("step 41->43 with update: seq_err=%0d", seq_err);
    chk("seq.skip", seq_err, 1);
    cycle(0, 0, 0, 0, 0);
    chk("seq.zero", seq_err, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    chk("seq.hold", seq_err, 1);
    cycle(0, 0, 1, 0, 0);
    chk("seq.cleared", seq_err, 0);
    cycle(0, 1, 0, 0, 1);
    chk("seq.legal", seq_err, 0);

    // Wrap of the capture interval across the counter rollover.
    cycle(0, 0, 1, 0, 1019);
    cycle(1, 1, 0, 0, 1020);
    for (int v = 1021; v < 1028; v++) cycle(0, 1, 0, 0, game_ts_t'(v));
    cycle(1, 1, 0, 0, 4);
    chk("wrap.err", seq_err, 0);
    chk("wrap.level", level, 2);
    cycle(0, 0, 0, 1, 4);
    $display("wrap capture: ts=%0d level=%0d", rd_ts, level);
    chk("wrap.ts", rd_ts, 4);
`ifdef GAME_LOG_DELTA_EN
    chk("wrap.delta", rd_delta, 8);
`endif

    // Asynchronous reset between edges with entries queued.
    do_reset();
    for (int i = 1; i <= 4; i++) cycle(1, 1, 0, 0, game_ts_t'(i));
    chk("async.level_before", level, 4);
    write_100m = 0; counter_update = 0; rd_ready = 0; counter_in = '0;
    #2 KEY0 = 1'b1;
    #1;
    $display("async reset: valid=%0d level=%0d", rd_valid, level);
    chk("async.valid", rd_valid, 0);
    chk("async.level", level, 0);
    model_reset();
    #2 KEY0 = 1'b0;

    // Randomized traffic against the model.
    @(posedge CLOCK50M); #1;
    for (int n = 0; n < 800; n++) begin
      int       r;
      bit       u;
      game_ts_t c;
      r = $urandom_range(0, 99);
      if (r < 60) begin
        u = 1; c = game_ts_t'(m_prev + 1);
      end else if (r < 63) begin
        u = 1; c = game_ts_t'(m_prev + 2);
      end else if (r < 66) begin
        u = 0; c = '0;
      end else if (r < 68) begin
        u = 0; c = game_ts_t'($urandom_range(0, 1023));
      end else begin
        u = 0; c = m_prev;
      end
      cycle($urandom_range(0, 99) < 55, u, $urandom_range(0, 99) < 2,
            $urandom_range(0, 99) < 40, c);
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/game_time_logger.md
# game_time_logger

Timestamp logger on the consuming side of the game clock's tick interface. Samples the 10-bit game-time counter on every deferred write strobe and queues the value in a small FIFO that a reader drains with a valid/ready handshake. Also checks the tick stream for consistency. Sits directly downstream of the game clock, between it and whatever display or transmit logic reports recorded times.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- TS_W, 10: timestamp width; matches the game clock counter.

Ports:
- CLOCK50M  in  1  system clock, 50 MHz, rising edge.
- KEY0  in  1  reset; asynchronous, active-high.
- counter_in  in  TS_W  game-time counter from the clock block.
- counter_update  in  1  one-cycle pulse; counter_in advanced this cycle.
- write_100m  in  1  one-cycle capture strobe, aligned to a tick.
- clear  in  1  synchronous flush of FIFO and sticky flags.
- rd_ready  in  1  reader accepts head entry.
- rd_valid  out  1  FIFO non-empty; head entry presented.
- rd_ts  out  TS_W  head timestamp.
- rd_delta  out  TS_W  head interval since previous capture. Present only with the macro enabled.
- level  out  $clog2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a capture was dropped.
- seq_err  out  1  sticky; tick stream inconsistency.

## Operation
- Capture: a write_100m sample of 1 at a rising edge pushes counter_in as it stands on that edge. That value already holds the post-tick count.
- Read: rd_valid && rd_ready at an edge pops the head. rd_ts/rd_delta show the new head, or hold stale data while rd_valid=0.
- FIFO: registered array, write/read pointers of $clog2(DEPTH)+1 bits, full/empty from the pointer MSB compare. No fall-through.
- Full, write only: capture dropped, overflow<=1, contents unchanged.
- Full, write and pop in the same cycle: both happen; no drop; level unchanged.
- Empty, pop: impossible, because rd_valid=0 (rd_ready ignored).
- Tick check:
  - prev_ts register loads counter_in every cycle.
  - On counter_update, counter_in != prev_ts+1 mod 2^TS_W sets seq_err.
  - counter_in changing while counter_update=0 sets seq_err, unless the new value is 0 (game reset path).
- clear: empties FIFO, level<=0, overflow<=0, seq_err<=0. Has priority over a same-cycle write or pop, which is discarded.
- Reset-state outputs: rd_valid=0, rd_ts=0, rd_delta=0, level=0, overflow=0, seq_err=0. Internal state: prev_ts=0, last_cap=0.
- Reset mid-operation: all queued entries are lost immediately (asynchronous).

## Timing
- Capture-to-visible latency: 1 cycle. A strobe at edge N gives rd_valid=1 after edge N, with rd_ts equal to the value sampled at N.
- Pop latency: head advances at the accepting edge; rd_valid falls after the edge that pops the last entry.
- level updates at the same edge as a push or pop.
- Back-to-back strobes on consecutive cycles are legal; each is queued.
- Sticky flags assert one cycle after the offending edge. They hold until clear or KEY0.

## Configuration
- GAME_LOG_DELTA_EN defined:
  - Each entry stores {ts, delta}, where delta = (ts - last_cap) mod 2^TS_W.
  - last_cap updates on every accepted capture only; dropped captures do not update it.
  - last_cap resets to 0 on KEY0 and on clear, so the first delta equals ts.
  - rd_delta port exists.
- Undefined: no delta storage and no last_cap register; rd_delta port is absent; entry width is TS_W.

## Structure
- Shared package game_pkg: TS_W default, timestamp typedef game_ts_t, entry typedef game_log_entry_t (ts plus delta under the macro).
- One sub-module: game_log_fifo, a parameterised synchronous FIFO with push/pop/clear, full/empty and level outputs.
- Top level holds the capture, tick check and delta logic.

## Test plan
- Reset and enable, then strobe with counter_in=5, 6, 7 on three ticks. Required: level=3; pops return rd_ts 5, 6, 7 in order; with the macro, rd_delta 5, 1, 1.
- Fill 8 entries, then strobe once more with no read. Required: level stays 8, overflow=1; the 9th value never appears.
- Full FIFO, write_100m and rd_ready in the same cycle. Required: level stays 8, overflow=0, new value lands at the tail.
- counter_in steps 41→43 together with counter_update. Required: seq_err=1 next cycle. Then a step 43→0 with no pulse: no additional error, and seq_err stays 1 until clear.
- Delta wrap: captures at 1020, then at 4. Required: rd_delta=8.
- Assert KEY0 asynchronously between clock edges with 4 entries queued. Required: rd_valid=0 and level=0 immediately, with no clock edge needed.
